// File: rtl/milStd1553.sv
// Shared MIL-STD-1553 definitions: word type tag, decoded line levels and default bit timing.
package milStd1553;

  typedef enum logic {
    WDATA    = 1'b0,
    WCOMMAND = 1'b1
  } word_type_e;

  localparam int HALF_BIT_DEFAULT = 25;

  // {P,N} after synchronization; both-high and both-low collapse to NUL
  localparam logic [1:0] LVL_NUL = 2'b00;
  localparam logic [1:0] LVL_HI  = 2'b10;
  localparam logic [1:0] LVL_LO  = 2'b01;

endpackage

// File: rtl/mil_receiver_pkg.sv
// Receiver-local types: FSM state encoding, counter width and sync tolerance default.
package mil_receiver_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC1,
    S_SYNC2,
    S_BITS,
    S_GAP
  } rx_state_e;

  localparam int SYNC_TOL_DEFAULT = 4;
  localparam int CNT_W            = 8;

  function automatic logic [1:0] lvl_inv(input logic [1:0] lvl);
    return {lvl[0], lvl[1]};
  endfunction

endpackage

// File: rtl/mil_receiver_if.sv
// Bus-side and word-side signals of the 1553 receiver, grouped for the transceiver/FIFO boundary.
interface mil_receiver_if;
  import milStd1553::*;

  logic        enable;
  logic        rx_p;
  logic        rx_n;
  logic        word_valid;
  word_type_e  word_type;
  logic [15:0] word_data;
  logic        parity_err;
  logic        manch_err;
  logic        busy;

  modport master (
    output enable, rx_p, rx_n,
    input  word_valid, word_type, word_data, parity_err, manch_err, busy
  );

  modport slave (
    input  enable, rx_p, rx_n,
    output word_valid, word_type, word_data, parity_err, manch_err, busy
  );

endinterface

// File: rtl/mil_line_sync.sv
// Two-flop synchronizers on the raw transceiver outputs followed by HI/LO/NUL level decode.
module mil_line_sync
  import milStd1553::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_p_i,
  input  logic       rx_n_i,
  output logic [1:0] level_o
);

  logic [1:0] p_q;
  logic [1:0] n_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q <= '0;
      n_q <= '0;
    end else begin
      p_q <= {p_q[0], rx_p_i};
      n_q <= {n_q[0], rx_n_i};
    end
  end

  assign level_o = (p_q[1] ^ n_q[1]) ? {p_q[1], n_q[1]} : LVL_NUL;

endmodule

// File: rtl/mil_receiver.sv
// MIL-STD-1553 word receiver: sync qualification, Manchester bit decode, odd parity check.
//   state | meaning
//   IDLE  | bus quiet or disabled; wait for a NUL->level start
//   SYNC1 | timing first sync half, expect a mid-sync flip at 3H +/- TOL
//   SYNC2 | verify second sync half; cnt measured from the flip (T0)
//   BITS  | sample both halves of 17 bits; cnt restarts each bit
//   GAP   | wait for word boundary, then chain into the next sync or go idle
module mil_receiver
  import milStd1553::*;
  import mil_receiver_pkg::*;
#(
  parameter int HALF_BIT = HALF_BIT_DEFAULT,
  parameter int SYNC_TOL = SYNC_TOL_DEFAULT
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  mil_receiver_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_H        = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] C_Q1       = CNT_W'(HALF_BIT / 2);
  localparam logic [CNT_W-1:0] C_Q3       = CNT_W'(HALF_BIT + HALF_BIT / 2);
  localparam logic [CNT_W-1:0] C_SYNC_END = CNT_W'(3 * HALF_BIT - 1);
  localparam logic [CNT_W-1:0] C_SYNC_MIN = CNT_W'(3 * HALF_BIT - SYNC_TOL);
  localparam logic [CNT_W-1:0] C_SYNC_MAX = CNT_W'(3 * HALF_BIT + SYNC_TOL);
  localparam logic [CNT_W-1:0] C_BIT_END  = CNT_W'(2 * HALF_BIT - 1);
  localparam logic [CNT_W-1:0] C_GAP_END  = CNT_W'(2 * HALF_BIT);

  logic [1:0]       level;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       s_q, s_d, h1_q, h1_d, prev_q;
  logic [4:0]       idx_q, idx_d;
  logic [15:0]      sh_q, sh_d, data_q, data_d;
  word_type_e       type_q, type_d;
  logic             perr_q, perr_d, valid_q, valid_d, merr_q, merr_d, busy_q, busy_d;
  logic             bit_ok, bit_val;

  mil_line_sync u_line_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .rx_p_i  (bus.rx_p),
    .rx_n_i  (bus.rx_n),
    .level_o (level)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign bit_ok  = (level != LVL_NUL) && (level != h1_q);
  assign bit_val = (h1_q == LVL_HI);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    s_d     = s_q;
    h1_d    = h1_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    type_d  = type_q;
    perr_d  = perr_q;
    valid_d = 1'b0;
    merr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level != LVL_NUL && prev_q == LVL_NUL) begin
          state_d = S_SYNC1;
          s_d     = level;
          cnt_d   = CNT_W'(1);
        end
      end
      S_SYNC1: begin
        if (level == LVL_NUL || cnt_q == '1) begin
          state_d = S_IDLE;
        end else if (level == lvl_inv(s_q)) begin
          if (cnt_q >= C_SYNC_MIN && cnt_q <= C_SYNC_MAX) begin
            state_d = S_SYNC2;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_SYNC2: begin
        if ((cnt_q == C_Q1 || cnt_q == C_Q3) && level != lvl_inv(s_q)) begin
          merr_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == C_SYNC_END) begin
          state_d = S_BITS;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_BITS: begin
        if (cnt_q == C_Q1) begin
          h1_d = level;
          if (level == LVL_NUL) begin
            merr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (cnt_q == C_Q3) begin
          if (!bit_ok) begin
            merr_d  = 1'b1;
            state_d = S_IDLE;
          end else if (idx_q == 5'd16) begin
            valid_d = 1'b1;
            data_d  = sh_q;
            type_d  = (s_q == LVL_HI) ? WCOMMAND : WDATA;
            perr_d  = ~^{sh_q, bit_val};
            state_d = S_GAP;
          end else begin
            sh_d = {sh_q[14:0], bit_val};
          end
        end
        if (cnt_q == C_BIT_END) begin
          cnt_d = '0;
          idx_d = idx_q + 5'd1;
        end
      end
      S_GAP: begin
        // Word boundary: the next sync may start on this very cycle
        if (cnt_q == C_GAP_END) begin
          if (level == LVL_NUL) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SYNC1;
            s_d     = level;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!bus.enable) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      merr_d  = 1'b0;
      data_d  = data_q;
      type_d  = type_q;
      perr_d  = perr_q;
    end
    busy_d = (state_d == S_SYNC1 && cnt_d >= C_H) || state_d == S_SYNC2 ||
             state_d == S_BITS || state_d == S_GAP;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      s_q     <= LVL_NUL;
      h1_q    <= LVL_NUL;
      prev_q  <= LVL_NUL;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      type_q  <= WDATA;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      merr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      h1_q    <= h1_d;
      prev_q  <= level;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      type_q  <= type_d;
      perr_q  <= perr_d;
      valid_q <= valid_d;
      merr_q  <= merr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.word_valid = valid_q;
  assign bus.word_type  = type_q;
  assign bus.word_data  = data_q;
  assign bus.parity_err = perr_q;
  assign bus.manch_err  = merr_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mil_receiver.sv
// Scoreboard bench for mil_receiver: expected words queued at send time, checked on wordValid.
module tb_mil_receiver;
  import milStd1553::*;

  localparam int H = 25;

  typedef struct {
    word_type_e  typ;
    logic [15:0] data;
    logic        perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   n_valid = 0;
  int   n_merr = 0;
  int   last_valid_cyc = 0;
  int   prev_valid_cyc = 0;
  int   last_merr_cyc = 0;
  logic busy_seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mil_receiver_if bus();

  mil_receiver #(.HALF_BIT(H), .SYNC_TOL(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Output monitor: sampled on the falling edge, pops the scoreboard on every word strobe
  initial begin
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_seen = 1'b1;
      if (bus.word_valid === 1'b1 || bus.manch_err === 1'b1) begin
        checks++;
        if (bus.word_valid === 1'b1 && bus.manch_err === 1'b1) begin
          failures++;
          $display("FAIL strobe_overlap: wordValid and manchErr both high at cyc %0d", cyc);
        end
      end
      if (bus.manch_err === 1'b1) begin
        n_merr++;
        last_merr_cyc = cyc;
      end
      if (bus.word_valid === 1'b1) begin
        n_valid++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got data=%h, required no word", bus.word_data);
        end else begin
          mon_e = exp_q.pop_front();
          checks++;
          if (bus.word_data !== mon_e.data) begin
            failures++;
            $display("FAIL word_data: got %h, required %h", bus.word_data, mon_e.data);
          end
          checks++;
          if (bus.word_type !== mon_e.typ) begin
            failures++;
            $display("FAIL word_type: got %0d, required %0d", bus.word_type, mon_e.typ);
          end
          checks++;
          if (bus.parity_err !== mon_e.perr) begin
            failures++;
            $display("FAIL parity_err: got %b, required %b", bus.parity_err, mon_e.perr);
          end
        end
      end
    end
  end

  // lvl: 0 = NUL, 1 = HI, 2 = LO; caller is aligned to a falling edge
  task automatic drive_half(input int lvl, input int n);
    bus.rx_p = (lvl == 1);
    bus.rx_n = (lvl == 2);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic is_cmd, input logic [15:0] d, input logic par,
                           input int sync_len, input int bad_bit, input int drop_bit,
                           input int stop_bit, output int mid_cyc);
    logic [16:0] w;
    int first;
    int second;
    w = {d, par};
    drive_half(is_cmd ? 1 : 2, sync_len);
    mid_cyc = cyc;
    drive_half(is_cmd ? 2 : 1, sync_len);
    for (int i = 0; i < 17; i++) begin
      if (i == stop_bit) return;
      if (drop_bit >= 0 && i == drop_bit) bus.enable = 1'b0;
      if (drop_bit >= 0 && i == drop_bit + 1) bus.enable = 1'b1;
      first  = w[16 - i] ? 1 : 2;
      second = w[16 - i] ? 2 : 1;
      if (i == bad_bit) begin
        first  = 1;
        second = 1;
      end
      drive_half(first, H);
      drive_half(second, H);
    end
  endtask

  task automatic test_reset();
    bus.enable = 1'b1;
    bus.rx_p = 1'b0;
    bus.rx_n = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.word_valid !== 1'b0 || bus.manch_err !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes: valid=%b merr=%b busy=%b, required 0 0 0",
               bus.word_valid, bus.manch_err, bus.busy);
    end
    checks++;
    if (bus.word_data !== 16'h0000 || bus.parity_err !== 1'b0 || bus.word_type !== WDATA) begin
      failures++;
      $display("FAIL reset_word: data=%h perr=%b type=%0d, required 0000 0 WDATA",
               bus.word_data, bus.parity_err, bus.word_type);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_command();
    int v0;
    int m0;
    int mid;
    v0 = n_valid;
    m0 = n_merr;
    busy_seen = 1'b0;
    exp_q.push_back('{WCOMMAND, 16'h02A1, 1'b0});
    send_word(1'b1, 16'h02A1, 1'b1, 3 * H, -1, -1, -1, mid);
    drive_half(0, 40);
    checks++;
    if (n_valid - v0 != 1) begin
      failures++;
      $display("FAIL cmd_count: got %0d words, required 1", n_valid - v0);
    end
    checks++;
    if (n_merr != m0) begin
      failures++;
      $display("FAIL cmd_merr: got %0d manchErr, required 0", n_merr - m0);
    end
    checks++;
    if (last_valid_cyc - mid < 915 || last_valid_cyc - mid > 916) begin
      failures++;
      $display("FAIL cmd_latency: got %0d clk after mid-sync pin edge, required 915..916",
               last_valid_cyc - mid);
    end
    checks++;
    if (busy_seen !== 1'b1) begin
      failures++;
      $display("FAIL cmd_busy_high: got %b, required 1 during word", busy_seen);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL cmd_busy_idle: got %b, required 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    int mid;
    v0 = n_valid;
    exp_q.push_back('{WCOMMAND, 16'h02A1, 1'b0});
    exp_q.push_back('{WDATA, 16'h02A1, 1'b0});
    send_word(1'b1, 16'h02A1, 1'b1, 3 * H, -1, -1, -1, mid);
    send_word(1'b0, 16'h02A1, 1'b1, 3 * H, -1, -1, -1, mid);
    drive_half(0, 40);
    checks++;
    if (n_valid - v0 != 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d words, required 2", n_valid - v0);
    end
    checks++;
    if (last_valid_cyc - prev_valid_cyc != 40 * H) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d clk, required %0d", last_valid_cyc - prev_valid_cyc, 40 * H);
    end
  endtask

  task automatic test_parity();
    int v0;
    int mid;
    v0 = n_valid;
    exp_q.push_back('{WDATA, 16'h02A1, 1'b1});
    send_word(1'b0, 16'h02A1, 1'b0, 3 * H, -1, -1, -1, mid);
    drive_half(0, 40);
    checks++;
    if (n_valid - v0 != 1) begin
      failures++;
      $display("FAIL parity_count: got %0d words, required 1", n_valid - v0);
    end
  endtask

  task automatic test_manchester();
    int v0;
    int m0;
    int mid;
    v0 = n_valid;
    m0 = n_merr;
    send_word(1'b1, 16'h02A1, 1'b1, 3 * H, 5, -1, -1, mid);
    drive_half(0, 40);
    checks++;
    if (n_merr - m0 != 1 || n_valid != v0) begin
      failures++;
      $display("FAIL manch_strobes: got merr=%0d words=%0d, required 1 and 0",
               n_merr - m0, n_valid - v0);
    end
    checks++;
    if (last_merr_cyc - mid < 365 || last_merr_cyc - mid > 366) begin
      failures++;
      $display("FAIL manch_timing: got %0d clk after mid-sync pin edge, required 365..366",
               last_merr_cyc - mid);
    end
    checks++;
    if (bus.parity_err !== 1'b1 || bus.word_type !== WDATA || bus.word_data !== 16'h02A1) begin
      failures++;
      $display("FAIL manch_hold: perr=%b type=%0d data=%h, required 1 WDATA 02a1",
               bus.parity_err, bus.word_type, bus.word_data);
    end
    exp_q.push_back('{WCOMMAND, 16'h02A1, 1'b0});
    send_word(1'b1, 16'h02A1, 1'b1, 3 * H, -1, -1, -1, mid);
    drive_half(0, 40);
    checks++;
    if (n_valid - v0 != 1) begin
      failures++;
      $display("FAIL manch_recover: got %0d words, required 1", n_valid - v0);
    end
  endtask

  task automatic test_sync_and_enable();
    int v0;
    int m0;
    int mid;
    v0 = n_valid;
    m0 = n_merr;
    send_word(1'b1, 16'h02A1, 1'b1, 2 * H, -1, -1, -1, mid);
    drive_half(0, 40);
    send_word(1'b0, 16'h1234, ~^16'h1234, 3 * H, -1, 3, -1, mid);
    drive_half(0, 40);
    checks++;
    if (n_valid != v0 || n_merr != m0) begin
      failures++;
      $display("FAIL sync_enable_silent: got words=%0d merr=%0d, required 0 0",
               n_valid - v0, n_merr - m0);
    end
    exp_q.push_back('{WDATA, 16'hB5C3, 1'b0});
    send_word(1'b0, 16'hB5C3, ~^16'hB5C3, 3 * H, -1, -1, -1, mid);
    drive_half(0, 40);
    checks++;
    if (n_valid - v0 != 1) begin
      failures++;
      $display("FAIL sync_enable_recover: got %0d words, required 1", n_valid - v0);
    end
  endtask

  task automatic test_reset_midword();
    int v0;
    int mid;
    v0 = n_valid;
    send_word(1'b1, 16'h02A1, 1'b1, 3 * H, -1, -1, 8, mid);
    drive_half(1, 10);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_busy: got %b, required 1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.word_valid !== 1'b0 || bus.manch_err !== 1'b0 ||
        bus.word_data !== 16'h0000 || bus.parity_err !== 1'b0 || bus.word_type !== WDATA) begin
      failures++;
      $display("FAIL rst_midword: busy=%b valid=%b merr=%b data=%h perr=%b type=%0d, required all 0",
               bus.busy, bus.word_valid, bus.manch_err, bus.word_data, bus.parity_err, bus.word_type);
    end
    @(negedge clk);
    drive_half(0, 3);
    rst_n = 1'b1;
    drive_half(0, 30);
    exp_q.push_back('{WCOMMAND, 16'h02A1, 1'b0});
    send_word(1'b1, 16'h02A1, 1'b1, 3 * H, -1, -1, -1, mid);
    drive_half(0, 40);
    checks++;
    if (n_valid - v0 != 1) begin
      failures++;
      $display("FAIL rst_recover: got %0d words, required 1", n_valid - v0);
    end
  endtask

  initial begin
    test_reset();
    test_command();
    test_back_to_back();
    test_parity();
    test_manchester();
    test_sync_and_enable();
    test_reset_midword();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d words outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
